// File: rtl/sim_end_ctrl.sv
// Simulation-control monitor: snoops RAM write ports for end-of-sim and heartbeat
// writes, runs a watchdog, drains, then reports done with a pass/fail verdict.
module sim_end_ctrl #(
  parameter int unsigned NumPorts      = 1,
  parameter int unsigned AddrWidth     = 14,
  parameter logic [31:0] MemBase       = 32'h1000_0000,
  parameter logic [31:0] EndSimAddr    = 32'h1000_7FF8,
  parameter logic [31:0] HeartbeatAddr = 32'h1000_7FF0,
  parameter int unsigned TimeoutCycles = 0,
  parameter int unsigned DrainCycles   = 16,
  parameter bit          EnableFinish  = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic [NumPorts-1:0]           req_i,
  input  logic [NumPorts-1:0]           we_i,
  input  logic [NumPorts-1:0]           port_rst_ni,
  input  logic [NumPorts*AddrWidth-1:0] addr_i,
  input  logic [NumPorts*32-1:0]        wdata_i,
  output logic                          end_req_o,
  output logic                          done_o,
  output logic                          pass_o,
  output logic [1:0]                    cause_o,
  output logic [31:0]                   code_o,
  output logic [31:0]                   cycles_o
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  localparam logic [31:0] TimeoutCode = 32'hDEAD_0000;
  localparam logic [31:0] DrainInit   = 32'(DrainCycles);
  localparam logic [31:0] WdLimit     = 32'(TimeoutCycles) - 32'd1;

  state_e      state_q;
  logic        end_req_q, done_q, pass_q;
  logic [1:0]  cause_q;
  logic [31:0] code_q, cycles_q, drain_q, wd_q;

  logic        any_end, any_hb, port_hit, wd_expire, accept;
  logic [31:0] end_code, byte_addr;

  always_comb begin
    any_end   = 1'b0;
    any_hb    = 1'b0;
    end_code  = '0;
    byte_addr = '0;
    port_hit  = 1'b0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      byte_addr = MemBase + 32'({addr_i[p*AddrWidth +: AddrWidth], 2'b00});
      port_hit  = req_i[p] & we_i[p] & port_rst_ni[p] & en_i;
      // Scanning upward and keeping the first match gives the lowest port priority.
      if (port_hit && byte_addr == EndSimAddr && !any_end) begin
        any_end  = 1'b1;
        end_code = wdata_i[p*32 +: 32];
      end
      if (port_hit && byte_addr == HeartbeatAddr) begin
        any_hb = 1'b1;
      end
    end
  end

  assign wd_expire = (TimeoutCycles != 0) && en_i && !any_hb && (wd_q == WdLimit);
  assign accept    = any_end || wd_expire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      end_req_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      cause_q   <= '0;
      code_q    <= '0;
      cycles_q  <= '0;
      drain_q   <= '0;
      wd_q      <= '0;
    end else begin
      end_req_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (cycles_q != '1) begin
            cycles_q <= cycles_q + 32'd1;
          end
          if (TimeoutCycles != 0) begin
            wd_q <= (!en_i || any_hb) ? '0 : wd_q + 32'd1;
          end
          if (accept) begin
            end_req_q <= 1'b1;
            cause_q   <= any_end ? 2'd1 : 2'd2;
            code_q    <= any_end ? end_code : TimeoutCode;
            if (DrainCycles == 0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              pass_q  <= any_end && (end_code == '0);
            end else begin
              state_q <= DRAIN;
              drain_q <= DrainInit;
            end
          end
        end
        DRAIN: begin
          if (drain_q == 32'd1) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= (cause_q == 2'd1) && (code_q == '0);
          end
          drain_q <= drain_q - 32'd1;
        end
        DONE: begin
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign end_req_o = end_req_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign cause_o   = cause_q;
  assign code_o    = code_q;
  assign cycles_o  = cycles_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (EnableFinish && rst_ni && done_q) begin
      $display("sim_end_ctrl: cause=%0d code=%08h cycles=%0d", cause_q, code_q, cycles_q);
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_sim_end_ctrl.sv
// Directed bench for sim_end_ctrl: single-port table scenarios plus multi-port,
// watchdog and reset sequences on a three-port instance.
module tb_sim_end_ctrl;

  localparam logic [13:0] EndW = 14'h1FFE;  // 0x1000_7FF8
  localparam logic [13:0] HbW  = 14'h1FFC;  // 0x1000_7FF0

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Single-port stimulus shared by instances a (drain 4) and c (drain 0)
  logic        a_en, a_req, a_we, a_prst;
  logic [13:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_end_req, a_done, a_pass, c_end_req, c_done, c_pass;
  logic [1:0]  a_cause, c_cause;
  logic [31:0] a_code, a_cycles, c_code, c_cycles;

  logic        b_en;
  logic [2:0]  b_req, b_we, b_prst;
  logic [41:0] b_addr;
  logic [95:0] b_wdata;
  logic        b_end_req, b_done, b_pass;
  logic [1:0]  b_cause;
  logic [31:0] b_code, b_cycles;

  sim_end_ctrl #(.NumPorts(1), .DrainCycles(4), .TimeoutCycles(0), .EnableFinish(1'b0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(a_en), .req_i(a_req), .we_i(a_we),
    .port_rst_ni(a_prst), .addr_i(a_addr), .wdata_i(a_wdata),
    .end_req_o(a_end_req), .done_o(a_done), .pass_o(a_pass), .cause_o(a_cause),
    .code_o(a_code), .cycles_o(a_cycles));

  sim_end_ctrl #(.NumPorts(1), .DrainCycles(0), .TimeoutCycles(0), .EnableFinish(1'b0)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .en_i(a_en), .req_i(a_req), .we_i(a_we),
    .port_rst_ni(a_prst), .addr_i(a_addr), .wdata_i(a_wdata),
    .end_req_o(c_end_req), .done_o(c_done), .pass_o(c_pass), .cause_o(c_cause),
    .code_o(c_code), .cycles_o(c_cycles));

  sim_end_ctrl #(.NumPorts(3), .DrainCycles(4), .TimeoutCycles(50), .EnableFinish(1'b0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(b_en), .req_i(b_req), .we_i(b_we),
    .port_rst_ni(b_prst), .addr_i(b_addr), .wdata_i(b_wdata),
    .end_req_o(b_end_req), .done_o(b_done), .pass_o(b_pass), .cause_o(b_cause),
    .code_o(b_code), .cycles_o(b_cycles));

  typedef struct {
    int          idle;
    logic        en, prst, we;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic        hit, pass;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic a_clear();
    a_en = 1'b1; a_req = 1'b0; a_we = 1'b0; a_prst = 1'b1; a_addr = '0; a_wdata = '0;
  endtask

  task automatic b_clear();
    b_req = '0; b_we = '0; b_prst = '1; b_addr = '0; b_wdata = '0;
  endtask

  task automatic b_write(input int p, input logic [13:0] addr, input logic [31:0] data);
    b_req[p] = 1'b1;
    b_we[p]  = 1'b1;
    b_addr[p*14 +: 14]  = addr;
    b_wdata[p*32 +: 32] = data;
  endtask

  // Leaves the bench at the negedge of cycle 0 after reset release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_clear();
    b_clear();
    b_en = 1'b1;
    #1;
    chk("rst_a_end_req", {31'd0, a_end_req}, 32'd0);
    chk("rst_a_done", {31'd0, a_done}, 32'd0);
    chk("rst_a_pass", {31'd0, a_pass}, 32'd0);
    chk("rst_a_cause", {30'd0, a_cause}, 32'd0);
    chk("rst_a_code", a_code, 32'd0);
    chk("rst_a_cycles", a_cycles, 32'd0);
    chk("rst_c_done", {31'd0, c_done}, 32'd0);
    chk("rst_b_done", {31'd0, b_done}, 32'd0);
    chk("rst_b_cycles", b_cycles, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    a_clear();
    b_clear();
    b_en = 1'b1;
    //          idle en prst we addr  wdata          hit   pass
    vecs[0] = '{100, 1'b1, 1'b1, 1'b1, EndW,  32'h0000_0000, 1'b1, 1'b1};
    vecs[1] = '{20,  1'b1, 1'b1, 1'b1, EndW,  32'h0000_0005, 1'b1, 1'b0};
    vecs[2] = '{20,  1'b1, 1'b1, 1'b0, EndW,  32'h0000_0000, 1'b0, 1'b0};
    vecs[3] = '{7,   1'b1, 1'b0, 1'b1, EndW,  32'h0000_0000, 1'b0, 1'b0};
    vecs[4] = '{7,   1'b0, 1'b1, 1'b1, EndW,  32'h0000_0000, 1'b0, 1'b0};
    vecs[5] = '{3,   1'b1, 1'b1, 1'b1, HbW,   32'h0000_0000, 1'b0, 1'b0};
    vecs[6] = '{3,   1'b1, 1'b1, 1'b1, 14'h1FFF, 32'h0000_0000, 1'b0, 1'b0};
    vecs[7] = '{0,   1'b1, 1'b1, 1'b1, EndW,  32'hFFFF_FFFF, 1'b1, 1'b0};

    for (int i = 0; i < 8; i++) begin
      do_reset();
      repeat (vecs[i].idle) @(negedge clk);
      a_en = vecs[i].en; a_prst = vecs[i].prst; a_we = vecs[i].we; a_req = 1'b1;
      a_addr = vecs[i].addr; a_wdata = vecs[i].wdata;
      @(negedge clk);  // cycle idle+1
      a_clear();
      chk("a_end_req", {31'd0, a_end_req}, {31'd0, vecs[i].hit});
      chk("a_cycles_n1", a_cycles, 32'(vecs[i].idle + 1));
      chk("a_cause_n1", {30'd0, a_cause}, vecs[i].hit ? 32'd1 : 32'd0);
      chk("a_code_n1", a_code, vecs[i].hit ? vecs[i].wdata : 32'd0);
      chk("a_done_n1", {31'd0, a_done}, 32'd0);
      chk("c_end_req", {31'd0, c_end_req}, {31'd0, vecs[i].hit});
      chk("c_done_n1", {31'd0, c_done}, {31'd0, vecs[i].hit});
      @(negedge clk);  // cycle idle+2
      chk("c_end_req_n2", {31'd0, c_end_req}, 32'd0);
      chk("c_done_n2", {31'd0, c_done}, {31'd0, vecs[i].hit});
      chk("c_pass", {31'd0, c_pass}, {31'd0, vecs[i].hit & vecs[i].pass});
      chk("a_end_req_n2", {31'd0, a_end_req}, 32'd0);
      repeat (2) @(negedge clk);  // cycle idle+4
      chk("a_done_n4", {31'd0, a_done}, 32'd0);
      @(negedge clk);  // cycle idle+5
      chk("a_done_n5", {31'd0, a_done}, {31'd0, vecs[i].hit});
      chk("a_pass", {31'd0, a_pass}, {31'd0, vecs[i].hit & vecs[i].pass});
      chk("a_cycles_n5", a_cycles, vecs[i].hit ? 32'(vecs[i].idle + 1) : 32'(vecs[i].idle + 5));
    end

    // Heartbeats every 40 cycles up to cycle 200, then expiry 50 cycles after the last.
    do_reset();
    for (int c = 0; c <= 250; c++) begin
      chk("b_wd_no_end", {31'd0, b_end_req}, 32'd0);
      if (c > 0 && c <= 200 && (c % 40) == 0) b_write(1, HbW, 32'h0);
      @(negedge clk);
      b_clear();
    end
    chk("b_to_end_req", {31'd0, b_end_req}, 32'd1);
    chk("b_to_cause", {30'd0, b_cause}, 32'd2);
    chk("b_to_code", b_code, 32'hDEAD_0000);
    chk("b_to_cycles", b_cycles, 32'd251);
    repeat (4) @(negedge clk);
    chk("b_to_done", {31'd0, b_done}, 32'd1);
    chk("b_to_pass", {31'd0, b_pass}, 32'd0);

    // Heartbeat on the expiry cycle wins; later end write, then reset mid-drain.
    do_reset();
    repeat (49) @(negedge clk);
    b_write(2, HbW, 32'h0);
    @(negedge clk);
    b_clear();
    chk("b_hb_vs_expiry", {31'd0, b_end_req}, 32'd0);
    repeat (49) @(negedge clk);
    b_write(0, EndW, 32'h33);
    @(negedge clk);
    b_clear();
    chk("b_sw_end_req", {31'd0, b_end_req}, 32'd1);
    chk("b_sw_cause", {30'd0, b_cause}, 32'd1);
    chk("b_sw_code", b_code, 32'h33);
    chk("b_sw_cycles", b_cycles, 32'd100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("b_rst_drain_cause", {30'd0, b_cause}, 32'd0);
    chk("b_rst_drain_code", b_code, 32'd0);
    chk("b_rst_drain_cycles", b_cycles, 32'd0);
    chk("b_rst_drain_flags", {29'd0, b_end_req, b_done, b_pass}, 32'd0);

    // Lowest port wins; writes during drain are ignored.
    do_reset();
    repeat (10) @(negedge clk);
    b_write(2, EndW, 32'd7);
    b_write(1, EndW, 32'd9);
    @(negedge clk);
    b_clear();
    chk("b_prio_end_req", {31'd0, b_end_req}, 32'd1);
    chk("b_prio_code", b_code, 32'd9);
    @(negedge clk);
    b_write(0, EndW, 32'd0);
    @(negedge clk);
    b_clear();
    chk("b_drain_ignore_code", b_code, 32'd9);
    chk("b_drain_end_req", {31'd0, b_end_req}, 32'd0);
    repeat (2) @(negedge clk);
    chk("b_prio_done", {31'd0, b_done}, 32'd1);
    chk("b_prio_pass", {31'd0, b_pass}, 32'd0);
    chk("b_prio_cause", {30'd0, b_cause}, 32'd1);
    chk("b_prio_cycles", b_cycles, 32'd11);

    // en_i low holds the watchdog at 0.
    do_reset();
    b_en = 1'b0;
    repeat (100) @(negedge clk);
    chk("b_en_low_no_end", {31'd0, b_end_req}, 32'd0);
    b_en = 1'b1;
    repeat (49) @(negedge clk);
    chk("b_en_pre_expiry", {31'd0, b_end_req}, 32'd0);
    @(negedge clk);
    chk("b_en_expiry", {31'd0, b_end_req}, 32'd1);
    chk("b_en_cycles", b_cycles, 32'd150);

    // End write on the expiry cycle: software cause.
    do_reset();
    repeat (49) @(negedge clk);
    b_write(2, EndW, 32'h44);
    @(negedge clk);
    b_clear();
    chk("b_tie_end_req", {31'd0, b_end_req}, 32'd1);
    chk("b_tie_cause", {30'd0, b_cause}, 32'd1);
    chk("b_tie_code", b_code, 32'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
